poly_decompress_ctrl: RTL and testbench

- Sequences one Kyber polynomial (256 coefficients) through the combinational `decompress` unit.
- Unpacks a byte stream of d-bit fields, LSB-first, and presents each field to `decompress`.
- Emits the 12-bit decompressed coefficients with index over a valid/ready interface.
- Sits between the ciphertext byte buffer and polynomial RAM/NTT input in the decryption path.

---
 rtl/poly_decompress_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_poly_decompress_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_decompress_ctrl.sv
// ---------------------------------------------------------------------------
// poly_decompress_ctrl
//
// Purpose:
//   Streams one Kyber polynomial (N_COEFF coefficients) through the
//   combinational decompress unit. Packed d-bit fields arrive as a byte
//   stream (LSB-first). They are unpacked from a small bit buffer and
//   decompressed to 12-bit coefficients. The coefficients leave over a
//   valid/ready interface together with their index.
//
// Ports:
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_start, i_d         start pulse and compression width (1,4,5,10,11)
//   i_byte, i_byte_valid,
//   o_byte_ready,
//   i_byte_last          packed byte input handshake (+ last-byte marker)
//   o_coeff, o_coeff_idx,
//   o_coeff_valid,
//   i_coeff_ready        decompressed coefficient output handshake
//   o_busy               polynomial in progress
//   o_done               one-cycle pulse when the last coefficient is taken
//   o_err                one-cycle pulse on illegal i_d (or length error)
//
// Optional feature:
//   POLY_DECOMP_LEN_CHK_EN - when defined, i_byte_last is checked against
//   the expected byte count 32*d. A premature i_byte_last aborts the
//   polynomial. A missing i_byte_last on the final byte only flags o_err.
// ---------------------------------------------------------------------------

// Combinational Kyber decompression: round(x * q / 2^d) with q = 3329.
module decompress (
    input  logic [10:0] i_field,
    input  logic [3:0]  i_d,
    output logic [11:0] o_coeff
);
    logic [23:0] prod;

    always_comb begin
        prod    = ({13'd0, i_field} * 24'd3329) + (24'd1 << (i_d - 4'd1));
        o_coeff = 12'(prod >> i_d);
    end
endmodule

module poly_decompress_ctrl #(
    parameter int N_COEFF = 256,
    parameter int BUF_W   = 18
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    input  logic [3:0]                 i_d,
    input  logic [7:0]                 i_byte,
    input  logic                       i_byte_valid,
    output logic                       o_byte_ready,
    input  logic                       i_byte_last,
    output logic [11:0]                o_coeff,
    output logic [$clog2(N_COEFF)-1:0] o_coeff_idx,
    output logic                       o_coeff_valid,
    input  logic                       i_coeff_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);
    localparam int IDX_W = $clog2(N_COEFF);
    localparam int CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         d_lat_q, d_lat_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]   unp_cnt_q, unp_cnt_d;
    logic [11:0]        coeff_q, coeff_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               d_legal;
    logic [8:0]         byte_total;
    logic               byte_ready;
    logic               byte_acc;
    logic               unpack;
    logic               handshake;
    logic [10:0]        field_mask;
    logic [10:0]        field;
    logic [11:0]        dec_coeff;
    logic [BUF_W-1:0]   buf_shift;
    logic [CNT_W-1:0]   cnt_base;
    logic [BUF_W-1:0]   byte_ext;
    logic [BUF_W-1:0]   buf_next;
    logic [CNT_W-1:0]   cnt_next;

    decompress u_decompress (
        .i_field (field),
        .i_d     (d_lat_q),
        .o_coeff (dec_coeff)
    );

    // Handshake qualifiers and the combined shift-out / append of the bit
    // buffer. When a field is unpacked and a byte is accepted in the same
    // cycle, the byte lands directly above the bits that remain after the
    // shift, so the new count is count - d + 8.
    always_comb begin
        d_legal    = (i_d == 4'd1) || (i_d == 4'd4) || (i_d == 4'd5) ||
                     (i_d == 4'd10) || (i_d == 4'd11);
        byte_total = {d_lat_q, 5'd0};
        byte_ready = (state_q == RUN) && (cnt_q <= CNT_W'(BUF_W - 8)) &&
                     (byte_cnt_q < byte_total);
        byte_acc   = byte_ready && i_byte_valid;
        handshake  = valid_q && i_coeff_ready;
        unpack     = (state_q == RUN) && (cnt_q >= CNT_W'(d_lat_q)) &&
                     (!valid_q || i_coeff_ready);

        // For d = 11 the shift wraps to 0 and the subtraction yields all ones.
        field_mask = (11'd1 << d_lat_q) - 11'd1;
        field      = buf_q[10:0] & field_mask;

        buf_shift  = unpack ? (buf_q >> d_lat_q) : buf_q;
        cnt_base   = unpack ? (cnt_q - CNT_W'(d_lat_q)) : cnt_q;
        byte_ext   = {{(BUF_W-8){1'b0}}, i_byte} << cnt_base;
        buf_next   = byte_acc ? (buf_shift | byte_ext) : buf_shift;
        cnt_next   = byte_acc ? (cnt_base + CNT_W'(8)) : cnt_base;
    end

    always_comb begin
        state_d    = state_q;
        d_lat_d    = d_lat_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        unp_cnt_d  = unp_cnt_q;
        coeff_d    = coeff_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (handshake) begin
            valid_d = 1'b0;
            idx_d   = idx_q + IDX_W'(1);
        end

        // A load in the same cycle as a handshake overrides the clear above.
        if (unpack) begin
            coeff_d   = dec_coeff;
            valid_d   = 1'b1;
            unp_cnt_d = unp_cnt_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (d_legal) begin
                        state_d    = RUN;
                        d_lat_d    = i_d;
                        buf_d      = '0;
                        cnt_d      = '0;
                        byte_cnt_d = '0;
                        unp_cnt_d  = '0;
                        idx_d      = '0;
                        valid_d    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                buf_d = buf_next;
                cnt_d = cnt_next;
                if (byte_acc) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                end
                if (unpack && (unp_cnt_q == IDX_W'(N_COEFF - 1))) begin
                    state_d = FLUSH;
                end
`ifdef POLY_DECOMP_LEN_CHK_EN
                if (byte_acc) begin
                    if (i_byte_last && (byte_cnt_q != byte_total - 9'd1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        valid_d = 1'b0;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else if (!i_byte_last &&
                                 (byte_cnt_q == byte_total - 9'd1)) begin
                        err_d = 1'b1;
                    end
                end
`endif
            end

            FLUSH: begin
                if (handshake && (idx_q == IDX_W'(N_COEFF - 1))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            d_lat_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            unp_cnt_q  <= '0;
            coeff_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_lat_q    <= d_lat_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            unp_cnt_q  <= unp_cnt_d;
            coeff_q    <= coeff_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifndef POLY_DECOMP_LEN_CHK_EN
    logic unused_byte_last;
    assign unused_byte_last = i_byte_last;
`endif

    assign o_byte_ready  = byte_ready;
    assign o_coeff       = coeff_q;
    assign o_coeff_idx   = idx_q;
    assign o_coeff_valid = valid_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;
endmodule

// File: tb/tb_poly_decompress_ctrl.sv
// ---------------------------------------------------------------------------
// tb_poly_decompress_ctrl
//
// Purpose:
//   Directed bench for poly_decompress_ctrl. For each polynomial the expected
//   coefficients are derived from the byte image and queued up front. They
//   are popped as the DUT hands coefficients over. Inputs are driven and
//   outputs are sampled on the falling clock edge.
//
// Ports: none (top-level bench).
//
// Optional feature: POLY_DECOMP_LEN_CHK_EN enables the length-check scenario.
// ---------------------------------------------------------------------------
module tb_poly_decompress_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [3:0]  i_d;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        i_byte_last;
    logic [11:0] o_coeff;
    logic [7:0]  o_coeff_idx;
    logic        o_coeff_valid;
    logic        i_coeff_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    poly_decompress_ctrl dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_d           (i_d),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_byte_ready  (o_byte_ready),
        .i_byte_last   (i_byte_last),
        .o_coeff       (o_coeff),
        .o_coeff_idx   (o_coeff_idx),
        .o_coeff_valid (o_coeff_valid),
        .i_coeff_ready (i_coeff_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [11:0] coeff;
        logic [7:0]  idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_mem [0:351];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         accepted_bytes;
    int         done_pulses;
    int         handshakes;
    bit         fin;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference decompression: round-half-up of x*3329/2^d.
    function automatic logic [11:0] expDecomp(input int x, input int d);
        return 12'(((2 * x * 3329) + (1 << d)) / (2 << d));
    endfunction

    task automatic buildExpected(input int d);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            int field = 0;
            for (int b = 0; b < d; b++) begin
                int pos = i * d + b;
                if (byte_mem[pos / 8][pos % 8]) field |= (1 << b);
            end
            e.coeff = expDecomp(field, d);
            e.idx   = 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d);
        @(negedge i_clk);
        i_start = 1'b1;
        i_d     = d;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_coeff"},       o_coeff, 0);
        checkOutput({tag, "_idx"},         o_coeff_idx, 0);
        checkOutput({tag, "_valid"},       o_coeff_valid, 0);
        checkOutput({tag, "_byte_ready"},  o_byte_ready, 0);
        checkOutput({tag, "_busy"},        o_busy, 0);
        checkOutput({tag, "_done"},        o_done, 0);
        checkOutput({tag, "_err"},         o_err, 0);
    endtask

    // mode 0: downstream always ready; mode 1: ready toggles every cycle.
    // stop_after > 0 abandons the polynomial after that many handshakes.
    task automatic runPoly(input int d, input int mode, input int stop_after);
        buildExpected(d);
        fin            = 1'b0;
        accepted_bytes = 0;
        done_pulses    = 0;
        handshakes     = 0;
        applyStimulus(4'(d));
        checkOutput("busy_after_start", o_busy, 1);
        fork
            begin : drv
                int k = 0;
                while (!fin) begin
                    i_byte       = (k < 32 * d) ? byte_mem[k] : 8'h00;
                    i_byte_last  = (k == 32 * d - 1);
                    i_byte_valid = 1'b1;
                    if (o_byte_ready) k++;
                    @(negedge i_clk);
                end
                i_byte_valid   = 1'b0;
                i_byte_last    = 1'b0;
                accepted_bytes = k;
            end
            begin : con
                int cyc = 0;
                while (1) begin
                    i_coeff_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
                    if (o_done) begin
                        done_pulses++;
                        checkOutput("busy_at_done", o_busy, 0);
                        break;
                    end
                    if (o_coeff_valid) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("extra_coeff", exp_q.size(), 1);
                            break;
                        end
                        checkOutput($sformatf("coeff%0d", exp_q[0].idx), o_coeff, exp_q[0].coeff);
                        checkOutput($sformatf("idx%0d", exp_q[0].idx), o_coeff_idx, exp_q[0].idx);
                        if (i_coeff_ready) begin
                            void'(exp_q.pop_front());
                            handshakes++;
                            if (handshakes == stop_after) break;
                        end
                    end
                    cyc++;
                    if (cyc > 6000) begin
                        checkOutput("timeout_cycles", cyc, 0);
                        break;
                    end
                    @(negedge i_clk);
                end
                fin = 1'b1;
            end
        join
        if (stop_after == 0) begin
            checkOutput("bytes_accepted", accepted_bytes, 32 * d);
            checkOutput("queue_empty", exp_q.size(), 0);
            checkOutput("done_count", done_pulses, 1);
            @(negedge i_clk);
            checkOutput("done_single_pulse", o_done, 0);
        end
    endtask

    initial begin
        i_rstn        = 1'b0;
        i_start       = 1'b0;
        i_d           = 4'd0;
        i_byte        = 8'h00;
        i_byte_valid  = 1'b0;
        i_byte_last   = 1'b0;
        i_coeff_ready = 1'b0;

        repeat (3) @(negedge i_clk);
        checkResetOutputs("reset");
        i_rstn = 1'b1;

        // Illegal width: error pulse only, no activity.
        applyStimulus(4'd7);
        checkOutput("illegal_err", o_err, 1);
        checkOutput("illegal_busy", o_busy, 0);
        checkOutput("illegal_byte_ready", o_byte_ready, 0);
        @(negedge i_clk);
        checkOutput("illegal_err_pulse", o_err, 0);
        checkOutput("illegal_busy_after", o_busy, 0);

        // d=1: single set bit in the first field.
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'h00;
        byte_mem[0] = 8'h01;
        runPoly(1, 0, 0);

        // d=4: fields 1 and 2, remainder zero.
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'h00;
        byte_mem[0] = 8'h21;
        runPoly(4, 0, 0);

        // d=10: all-ones fields with a stalling consumer.
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'hFF;
        runPoly(10, 1, 0);

        // Random images for the remaining widths.
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'($urandom);
        runPoly(5, 0, 0);
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'($urandom);
        runPoly(11, 1, 0);

        // Reset in the middle of a polynomial, then a clean restart.
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'($urandom);
        runPoly(4, 0, 100);
        i_rstn = 1'b0;
        @(negedge i_clk);
        checkResetOutputs("mid_reset");
        i_rstn = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 352; k++) byte_mem[k] = 8'($urandom);
        runPoly(4, 0, 0);

`ifdef POLY_DECOMP_LEN_CHK_EN
        begin
            int k      = 0;
            int dn     = 0;
            bit seen   = 1'b0;
            for (int j = 0; j < 352; j++) byte_mem[j] = 8'($urandom);
            applyStimulus(4'd5);
            for (int cyc = 0; cyc < 1000; cyc++) begin
                i_byte        = byte_mem[k];
                i_byte_last   = (k == 50);
                i_byte_valid  = 1'b1;
                i_coeff_ready = 1'b1;
                if (o_err) begin
                    seen = 1'b1;
                    break;
                end
                if (o_done) dn++;
                if (o_byte_ready) k++;
                @(negedge i_clk);
            end
            checkOutput("lenchk_err_seen", seen, 1);
            checkOutput("lenchk_busy", o_busy, 0);
            checkOutput("lenchk_no_done", dn, 0);
            checkOutput("lenchk_bytes", k, 51);
            i_byte_valid = 1'b0;
            i_byte_last  = 1'b0;
            @(negedge i_clk);
            checkOutput("lenchk_err_pulse", o_err, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
